// File: rtl/router_input_port.sv
`default_nettype none
// ============================================================================
// Module      : router_input_port
// Description : Ingress stage for one input of the five-port mesh router.
//               Buffers 256-bit packets in a DEPTH-entry FIFO, computes the
//               XY output direction once at enqueue and stores it with each
//               entry, and presents head packet + one-hot route to the router.
//               Packets whose destination lies outside the mesh are accepted
//               on the link handshake but discarded, and flag err_dest.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - upstream link handshake
//               in_packet[255:0]    - packet, dst_x/dst_y in the low bits
//               out_valid/out_ready - router-side handshake
//               out_packet[255:0]   - head packet
//               out_route[4:0]      - one-hot L/N/E/S/W direction of head
//               occupancy           - entries currently buffered
//               err_dest            - sticky out-of-range drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_port #(
    parameter int DEPTH   = 4,
    parameter int COORD_W = 4,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [255:0]             in_packet,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [255:0]             out_packet,
    output logic [4:0]               out_route,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_dest
);

    localparam int                   c_PTR_W = $clog2(DEPTH);
    localparam int                   c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [COORD_W-1:0]   c_MY_X  = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0]   c_MY_Y  = COORD_W'(MY_Y);

    localparam logic [4:0] c_ROUTE_LOCAL = 5'b00001;
    localparam logic [4:0] c_ROUTE_NORTH = 5'b00010;
    localparam logic [4:0] c_ROUTE_EAST  = 5'b00100;
    localparam logic [4:0] c_ROUTE_SOUTH = 5'b01000;
    localparam logic [4:0] c_ROUTE_WEST  = 5'b10000;

    // Storage is deliberately not reset; out_valid qualifies its contents.
    logic [255:0]         r_mem_pkt   [DEPTH];
    logic [4:0]           r_mem_route [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_err_dest;

    logic [COORD_W-1:0]   w_dst_x;
    logic [COORD_W-1:0]   w_dst_y;
    logic                 w_in_range;
    logic [4:0]           w_route;
    logic                 w_push_hs;
    logic                 w_push;
    logic                 w_pop;

    assign w_dst_x = in_packet[COORD_W-1:0];
    assign w_dst_y = in_packet[2*COORD_W-1:COORD_W];

    // Compare at 32 bits so a mesh dimension of 2**COORD_W is not truncated.
    assign w_in_range = (32'(w_dst_x) < 32'(MESH_X)) &&
                        (32'(w_dst_y) < 32'(MESH_Y));

    // Dimension-ordered routing: resolve X first, then Y.
    always_comb begin
        w_route = c_ROUTE_LOCAL;
        if (w_dst_x > c_MY_X) begin
            w_route = c_ROUTE_EAST;
        end else if (w_dst_x < c_MY_X) begin
            w_route = c_ROUTE_WEST;
        end else if (w_dst_y > c_MY_Y) begin
            w_route = c_ROUTE_NORTH;
        end else if (w_dst_y < c_MY_Y) begin
            w_route = c_ROUTE_SOUTH;
        end
    end

    // in_ready depends on the registered count only: no pass-through when
    // full, which keeps the link-side ready free of router-side timing.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);

    assign w_push_hs = in_valid && in_ready;
    assign w_push    = w_push_hs && w_in_range;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err_dest <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_hs && !w_in_range) begin
                r_err_dest <= 1'b1;
            end
        end
    end

    // The write slot never aliases the head while the FIFO is non-empty and
    // not full, so the presented head stays stable across stalls.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pkt[r_wr_ptr]   <= in_packet;
            r_mem_route[r_wr_ptr] <= w_route;
        end
    end

    assign out_packet = r_mem_pkt[r_rd_ptr];
    assign out_route  = r_mem_route[r_rd_ptr];
    assign occupancy  = r_count;
    assign err_dest   = r_err_dest;

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        w_pop |-> (r_count != '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> (r_count != c_FULL));

endmodule
`default_nettype wire

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- Per-port ingress stage that sits directly upstream of the five-port mesh router: one instance per router input.
- Buffers 256-bit packets arriving from a link in a small FIFO.
- Computes the XY output direction once at enqueue and stores it alongside each packet.
- Presents the head packet plus a one-hot route to the router's in_valid/in_packet inputs, consuming on a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- COORD_W, 4, width of each X/Y coordinate field in the header.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.
- MESH_X, 4, number of columns; legal dst_x is 0..MESH_X-1.
- MESH_Y, 4, number of rows; legal dst_y is 0..MESH_Y-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream link presents a packet.
- in_packet  input  256  packet; dst_x = [COORD_W-1:0], dst_y = [2*COORD_W-1:COORD_W].
- in_ready  output  1  port can accept a packet this cycle.
- out_valid  output  1  head packet available to the router.
- out_packet  output  256  head packet.
- out_route  output  5  one-hot direction: bit0 LOCAL, bit1 NORTH, bit2 EAST, bit3 SOUTH, bit4 WEST.
- out_ready  input  1  router consumes the head this cycle.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- err_dest  output  1  sticky: a packet with an out-of-range destination was dropped.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Read/write pointers and count cleared.
  - out_valid=0, in_ready=1, occupancy=0, err_dest=0.
  - FIFO contents are not reset; out_packet and out_route are don't-care while out_valid=0.
- in_ready = (count != DEPTH), a function of registered count only.
  - No pass-through when full: in_ready stays 0 even if a pop occurs in the same cycle.
- Push: in_valid && in_ready at a rising edge.
- Pop: out_valid && out_ready at a rising edge.
- out_valid = (count != 0). out_packet and out_route come from the entry at rd_ptr.
- Latency: a packet pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass.
- Route computation, performed at push and stored with the entry:
  - dst_x > MY_X: EAST.
  - dst_x < MY_X: WEST.
  - otherwise dst_y > MY_Y: NORTH.
  - otherwise dst_y < MY_Y: SOUTH.
  - otherwise: LOCAL.
  - Comparisons are unsigned, COORD_W bits.
- Out-of-range destination (dst_x >= MESH_X or dst_y >= MESH_Y):
  - The handshake still completes; in_ready is honoured normally.
  - The packet is not enqueued, and count and pointers are unchanged.
  - err_dest sets the following cycle and holds until reset.
- Simultaneous push and pop (only possible when 0 < count < DEPTH): count unchanged, both pointers advance.
  - If the pushed packet is dropped, only the pop takes effect.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and occupancy = count.
- out_packet and out_route must stay stable while out_valid=1 and out_ready=0.
- Pop while empty and push while full cannot occur by construction; assertions check both.
- Reset mid-operation: all buffered packets are discarded and no partial pop is presented.

Test Plan:
- MY_X=1, MY_Y=1. Push one packet each with dst (2,1), (0,1), (1,2), (1,0), (1,1); out_ready=1.
  - Required: out_route 00100, 10000, 00010, 01000, 00001 in order.
  - Each appears exactly 1 cycle after its push; payloads match.
- out_ready=0, push continuously with DEPTH=4.
  - Required: in_ready drops after the 4th accept, occupancy=4, and the 5th packet is held upstream.
  - Then raise out_ready for 1 cycle while in_valid=1: required pop only, occupancy=3, in_ready=1 next cycle.
- Steady stream with in_valid=1 and out_ready=1, 20 packets with incrementing payload.
  - Required: occupancy stays at 1 after the first cycle.
  - All 20 packets emerge in order across a pointer wrap.
- Push dst (7,0) with MESH_X=4.
  - Required: accepted, occupancy stays 0, out_valid stays 0, err_dest=1 next cycle and remains set.
  - A following valid packet routes normally.
- Fill with 3 packets, then assert rst_n=0 asynchronously mid-cycle.
  - Required: out_valid=0, occupancy=0, in_ready=1, err_dest=0 immediately.
  - After release, the next push is the first packet out.
- Random in_valid/out_ready at 50% for 1000 packets against a scoreboard.
  - Required: no loss, duplication, or reorder; out_packet and out_route stable while stalled.
